// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: command encodings and FSM states shared by the T-bank controller.
package tff_ctrl_pkg;
    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_TOGGLE = 2'b01;
    localparam logic [1:0] OP_RIPPLE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with asynchronous active-high clear.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= q ^ t;
    end
endmodule

// File: rtl/tff_bank_ctrl.sv
// tff_bank_ctrl: command sequencer that drives a bank of T cells through their toggle inputs only.
module tff_bank_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] t_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);
    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   carry;

    // Increment toggles: bit i flips when every lower bit is one.
    assign carry[0] = 1'b1;
    for (genvar k = 1; k < WIDTH; k++) begin : g_carry
        assign carry[k] = &q[k-1:0];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (.clk(clk), .rst(rst), .t(t_out[i]), .q(q[i]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_HOLD;
            mask_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mask_d  = mask_q;
        rem_d   = rem_q;
        t_out   = '0;
        unique case (state_q)
            IDLE: if (cmd_valid) begin
                op_d    = cmd_op;
                mask_d  = cmd_mask;
                rem_d   = (cmd_op == OP_CLEAR) ? CNT_W'(1) : cmd_count;
                state_d = (cmd_op == OP_HOLD || (cmd_op != OP_CLEAR && cmd_count == '0)) ? DONE : RUN;
            end
            RUN: begin
                t_out   = (op_q == OP_TOGGLE) ? mask_q : (op_q == OP_RIPPLE) ? carry : q;
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? DONE : RUN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule
